// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared-RAM port arbiter: requester handshake, read responses and RAM port.
// slave = arbiter side, master = requester/RAM environment side.
interface mem_port_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int AW    = 4,
    parameter int WIDTH = 128
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_we;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_din;
    logic [NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]      rsp_data;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [WIDTH-1:0]      mem_din;
    logic [WIDTH-1:0]      mem_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_din, mem_dout,
        output req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_din, mem_dout,
        input  req_ready, rsp_valid, rsp_data, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one READ_FIRST RAM port between NREQ requesters; read data returns one cycle after grant.
// Define MEM_ARB_RR_EN for round-robin priority; otherwise fixed priority (lowest index wins).
module mem_port_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int SIZE  = 16,
    parameter  int WIDTH = 128,
    localparam int AW    = $clog2(SIZE),
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);
    logic [PW-1:0] prio;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          found;
    logic          xfer;

    logic          rd_pend_q, rd_pend_d;
    logic [PW-1:0] rd_id_q, rd_id_d;

    // Search starts at prio and wraps, first valid requester wins.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(prio) + k) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Every valid request is granted to somebody, so any valid request implies a transfer.
    assign xfer = (|bus.req_valid) && !rst;

    always_comb begin
        bus.req_ready = '0;
        bus.mem_en    = xfer;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        if (xfer) begin
            bus.req_ready[win] = 1'b1;
            bus.mem_we         = bus.req_we[win];
            bus.mem_addr       = bus.req_addr[win*AW +: AW];
            bus.mem_din        = bus.req_din[win*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        rd_pend_d = xfer && !bus.req_we[win];
        rd_id_d   = rd_pend_d ? win : rd_id_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= '0;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (rd_pend_q) begin
            bus.rsp_valid[rd_id_q] = 1'b1;
        end
    end

    assign bus.rsp_data = bus.mem_dout;

`ifdef MEM_ARB_RR_EN
    logic [PW-1:0] prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (xfer) begin
            prio_d = PW'((int'(win) + 1) % NREQ);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;
`else
    assign prio = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a READ_FIRST RAM model on the memory port.
// Expectations follow MEM_ARB_RR_EN when defined, fixed priority otherwise.
module tb_mem_port_arbiter;
    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int WIDTH = 128;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   prev_g;
    int   g;

    logic [WIDTH-1:0] mem [16];

    mem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) bus ();

    mem_port_arbiter #(.NREQ(NREQ), .SIZE(16), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // READ_FIRST RAM, reloaded with 0x1000+addr while reset is held
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= WIDTH'(32'h1000 + i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
            bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        bus.req_addr[i*AW +: AW]      = a;
        bus.req_din[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_we    = 4'b0000;
        bus.req_addr  = '0;
        bus.req_din   = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), '0);

        #2;
        chk("rst_ready",   bus.req_ready, 0);
        chk("rst_mem_en",  bus.mem_en,    0);
        chk("rst_rsp",     bus.rsp_valid, 0);
        chk("rst_mem_we",  bus.mem_we,    0);
        chk("rst_mem_adr", bus.mem_addr,  0);
        @(posedge clk);
        nxt();
        rst = 1'b0;

        // All requesters reading their own index as address, held for 8 cycles
        prev_g = -1;
        for (int c = 0; c < 8; c++) begin
            #3;
            g = RR ? (c % 4) : 0;
            chk("rr_grant", bus.req_ready, 4'b0001 << g);
            if (prev_g >= 0) begin
                chk("rr_rsp_valid", bus.rsp_valid, 4'b0001 << prev_g);
                chk("rr_rsp_data",  bus.rsp_data,  WIDTH'(32'h1000 + prev_g));
            end
            prev_g = g;
            nxt();
        end

        // Requester 2 writes 0xA5A5 to address 3
        bus.req_valid = 4'b0100;
        bus.req_we    = 4'b0100;
        set_req(2, 4'd3, 128'hA5A5);
        #3;
        chk("wr_grant",    bus.req_ready, 4'b0100);
        chk("wr_mem_we",   bus.mem_we,    1);
        chk("wr_mem_addr", bus.mem_addr,  3);
        chk("wr_mem_din",  bus.mem_din,   128'hA5A5);
        chk("wr_last_rsp", bus.rsp_valid, 4'b0001 << prev_g);
        nxt();

        // Requester 1 reads address 3 right after the write
        bus.req_valid = 4'b0010;
        bus.req_we    = 4'b0000;
        set_req(1, 4'd3, '0);
        #3;
        chk("rd_grant",   bus.req_ready, 4'b0010);
        chk("rd_mem_we",  bus.mem_we,    0);
        chk("wr_no_rsp",  bus.rsp_valid, 0);
        nxt();
        bus.req_valid = 4'b0000;
        #3;
        chk("wr_rd_rsp",  bus.rsp_valid, 4'b0010);
        chk("wr_rd_data", bus.rsp_data,  128'hA5A5);
        chk("idle_en",    bus.mem_en,    0);
        nxt();

        // Back-to-back reads: requester 0 addr 5, then requester 3 addr 6
        bus.req_valid = 4'b0001;
        set_req(0, 4'd5, '0);
        set_req(3, 4'd6, '0);
        #3;
        chk("b2b_grant0", bus.req_ready, 4'b0001);
        chk("b2b_addr0",  bus.mem_addr,  5);
        chk("b2b_norsp",  bus.rsp_valid, 0);
        nxt();
        bus.req_valid = 4'b1000;
        #3;
        chk("b2b_grant3", bus.req_ready, 4'b1000);
        chk("b2b_rsp0",   bus.rsp_valid, 4'b0001);
        chk("b2b_data0",  bus.rsp_data,  128'h1005);
        nxt();

        // Read by requester 2 (addr 7), then reset pulsed during its response cycle
        bus.req_valid = 4'b0100;
        set_req(2, 4'd7, '0);
        #3;
        chk("b2b_rsp3",   bus.rsp_valid, 4'b1000);
        chk("b2b_data3",  bus.rsp_data,  128'h1006);
        chk("mr_grant",   bus.req_ready, 4'b0100);
        nxt();
        rst           = 1'b1;
        bus.req_valid = 4'b0000;
        #3;
        chk("mr_rsp_clr", bus.rsp_valid, 0);
        nxt();
        chk("mr_rsp_hold", bus.rsp_valid, 0);
        rst           = 1'b0;
        bus.req_valid = 4'b1111;
        #3;
        chk("mr_prio0",   bus.req_ready, 4'b0001);
        chk("mr_no_rsp",  bus.rsp_valid, 0);
        nxt();
        bus.req_valid = 4'b0000;
        #3;
        chk("mr_rsp_new",  bus.rsp_valid, 4'b0001);
        chk("mr_data_new", bus.rsp_data,  128'h1005);
        nxt();

        // Sparse: requester 3 alone, then requester 1 alone
        bus.req_valid = 4'b1000;
        #3;
        chk("sp_grant3", bus.req_ready, 4'b1000);
        chk("sp_en3",    bus.mem_en,    1);
        chk("sp_addr3",  bus.mem_addr,  6);
        nxt();
        bus.req_valid = 4'b0010;
        #3;
        chk("sp_grant1", bus.req_ready, 4'b0010);
        chk("sp_addr1",  bus.mem_addr,  3);
        chk("sp_rsp3",   bus.rsp_valid, 4'b1000);
        chk("sp_data3",  bus.rsp_data,  128'h1006);
        nxt();
        bus.req_valid = 4'b0000;
        #3;
        chk("sp_idle_ready", bus.req_ready, 0);
        chk("sp_idle_en",    bus.mem_en,    0);
        chk("sp_idle_addr",  bus.mem_addr,  0);
        chk("sp_rsp1",       bus.rsp_valid, 4'b0010);
        chk("sp_data1",      bus.rsp_data,  128'h1003);
        nxt();
        #3;
        chk("final_rsp", bus.rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
